// File: rtl/nn_pkg.sv
`default_nettype none
// ============================================================================
// nn_pkg : register map and AXI response codes for the nn config slave
// Rev 1.0
// ============================================================================
package nn_pkg;

   localparam logic [7:0] REG_WEIGHT = 8'h00;
   localparam logic [7:0] REG_BIAS   = 8'h04;
   localparam logic [7:0] REG_RESULT = 8'h08;
   localparam logic [7:0] REG_LAYER  = 8'h0C;
   localparam logic [7:0] REG_NEURON = 8'h10;
   localparam logic [7:0] REG_OUTPUT = 8'h14;
   localparam logic [7:0] REG_CTRL   = 8'h18;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   localparam int CTRL_INTR_EN = 0;
   localparam int CTRL_PTR_CLR = 1;
   localparam int CTRL_PENDING = 8;

endpackage
`default_nettype wire

// File: rtl/nn_axil_out_fifo.sv
`default_nettype none
// ============================================================================
// nn_axil_out_fifo : captured neuron-output array with wrapping pop pointer
// Rev 1.0
// ============================================================================
module nn_axil_out_fifo #(
   parameter int NUM_OUT = 10,
   parameter int OUT_W   = 16
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     capture,
   input  logic [NUM_OUT*OUT_W-1:0] neuron_outs,
   input  logic                     pop,
   input  logic                     clear,
   output logic [OUT_W-1:0]         head
);

   localparam int PTR_W = (NUM_OUT > 1) ? $clog2(NUM_OUT) : 1;

   logic [OUT_W-1:0] slots [NUM_OUT];
   logic [PTR_W-1:0] ptr;

   // Capture outranks an explicit clear, which outranks a pop.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_OUT; i++) slots[i] <= '0;
         ptr <= '0;
      end else if (capture) begin
         for (int i = 0; i < NUM_OUT; i++) slots[i] <= neuron_outs[i*OUT_W +: OUT_W];
         ptr <= '0;
      end else if (clear) begin
         ptr <= '0;
      end else if (pop) begin
         ptr <= (ptr == PTR_W'(NUM_OUT - 1)) ? '0 : ptr + PTR_W'(1);
      end
   end

   assign head = slots[ptr];

endmodule
`default_nettype wire

// File: rtl/nn_axil_cfg_slave.sv
`default_nettype none
// ============================================================================
// nn_axil_cfg_slave : AXI4-Lite config/readback register file for nn_autoGen_top
// Rev 1.0
// ============================================================================
module nn_axil_cfg_slave
   import nn_pkg::*;
#(
   parameter int DATA_W  = 32,
   parameter int NUM_OUT = 10,
   parameter int OUT_W   = 16
) (
   input  logic                     s_axi_aclk,
   input  logic                     s_axi_aresetn,
   input  logic [31:0]              s_axi_awaddr,
   input  logic [2:0]               s_axi_awprot,
   input  logic                     s_axi_awvalid,
   output logic                     s_axi_awready,
   input  logic [DATA_W-1:0]        s_axi_wdata,
   input  logic [DATA_W/8-1:0]      s_axi_wstrb,
   input  logic                     s_axi_wvalid,
   output logic                     s_axi_wready,
   output logic [1:0]               s_axi_bresp,
   output logic                     s_axi_bvalid,
   input  logic                     s_axi_bready,
   input  logic [31:0]              s_axi_araddr,
   input  logic [2:0]               s_axi_arprot,
   input  logic                     s_axi_arvalid,
   output logic                     s_axi_arready,
   output logic [DATA_W-1:0]        s_axi_rdata,
   output logic [1:0]               s_axi_rresp,
   output logic                     s_axi_rvalid,
   input  logic                     s_axi_rready,
   output logic                     weight_valid,
   output logic [DATA_W-1:0]        weight_data,
   output logic                     bias_valid,
   output logic [DATA_W-1:0]        bias_data,
   output logic [DATA_W-1:0]        layer_number,
   output logic [DATA_W-1:0]        neuron_number,
   input  logic                     result_valid,
   input  logic [DATA_W-1:0]        result_value,
   input  logic [NUM_OUT*OUT_W-1:0] neuron_outs,
   output logic                     intr
);

   logic              aw_ready;
   logic              wr_en, rd_en;
   logic [7:0]        wr_off, rd_off;
   logic              wr_ok, rd_ok;
   logic [DATA_W-1:0] result_reg, rd_word, ctrl_word;
   logic              intr_en, pending, intr_en_nxt, pending_nxt;
   logic              ptr_clear, pop;
   logic [OUT_W-1:0]  head;
   logic              unused_bits;

   function automatic logic [DATA_W-1:0] merge_strb(input logic [DATA_W-1:0]   cur,
                                                    input logic [DATA_W-1:0]   data,
                                                    input logic [DATA_W/8-1:0] strb);
      merge_strb = cur;
      for (int b = 0; b < DATA_W/8; b++)
         if (strb[b]) merge_strb[b*8 +: 8] = data[b*8 +: 8];
   endfunction

   assign s_axi_awready = aw_ready;
   assign s_axi_wready  = aw_ready;
   assign wr_en     = aw_ready && s_axi_awvalid && s_axi_wvalid;
   assign rd_en     = s_axi_arready && s_axi_arvalid;
   assign wr_off    = {s_axi_awaddr[7:2], 2'b00};
   assign rd_off    = {s_axi_araddr[7:2], 2'b00};
   assign wr_ok     = wr_off inside {REG_WEIGHT, REG_BIAS, REG_LAYER, REG_NEURON, REG_CTRL};
   assign rd_ok     = rd_off inside {REG_RESULT, REG_LAYER, REG_NEURON, REG_OUTPUT, REG_CTRL};
   assign ptr_clear = wr_en && (wr_off == REG_CTRL) && s_axi_wstrb[0] && s_axi_wdata[CTRL_PTR_CLR];
   assign pop       = rd_en && (rd_off == REG_OUTPUT);
   assign unused_bits = ^{s_axi_awprot, s_axi_arprot, s_axi_awaddr[31:8], s_axi_awaddr[1:0],
                          s_axi_araddr[31:8], s_axi_araddr[1:0]};

   // A new result always wins over the clear caused by reading it.
   always_comb begin
      pending_nxt = pending;
      intr_en_nxt = intr_en;
      if (rd_en && rd_off == REG_RESULT) pending_nxt = 1'b0;
      if (result_valid)                  pending_nxt = 1'b1;
      if (wr_en && wr_off == REG_CTRL && s_axi_wstrb[0])
         intr_en_nxt = s_axi_wdata[CTRL_INTR_EN];
   end

   always_comb begin
      ctrl_word               = '0;
      ctrl_word[CTRL_INTR_EN] = intr_en;
      ctrl_word[CTRL_PENDING] = pending;
      case (rd_off)
         REG_RESULT: rd_word = result_reg;
         REG_LAYER:  rd_word = layer_number;
         REG_NEURON: rd_word = neuron_number;
         REG_OUTPUT: rd_word = DATA_W'(head);
         REG_CTRL:   rd_word = ctrl_word;
         default:    rd_word = '0;
      endcase
   end

   always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
      if (!s_axi_aresetn) begin
         aw_ready      <= 1'b0;
         s_axi_bvalid  <= 1'b0;
         s_axi_bresp   <= RESP_OKAY;
         s_axi_arready <= 1'b0;
         s_axi_rvalid  <= 1'b0;
         s_axi_rresp   <= RESP_OKAY;
         s_axi_rdata   <= '0;
         weight_valid  <= 1'b0;
         weight_data   <= '0;
         bias_valid    <= 1'b0;
         bias_data     <= '0;
         layer_number  <= '0;
         neuron_number <= '0;
         result_reg    <= '0;
         intr_en       <= 1'b1;
         pending       <= 1'b0;
         intr          <= 1'b0;
      end else begin
         // Readies self-clear so each acceptance is a single-cycle pulse.
         aw_ready      <= !aw_ready && s_axi_awvalid && s_axi_wvalid && !s_axi_bvalid;
         s_axi_arready <= !s_axi_arready && s_axi_arvalid && !s_axi_rvalid;

         if (wr_en) begin
            s_axi_bvalid <= 1'b1;
            s_axi_bresp  <= wr_ok ? RESP_OKAY : RESP_SLVERR;
         end else if (s_axi_bready) begin
            s_axi_bvalid <= 1'b0;
         end

         if (rd_en) begin
            s_axi_rvalid <= 1'b1;
            s_axi_rdata  <= rd_word;
            s_axi_rresp  <= rd_ok ? RESP_OKAY : RESP_SLVERR;
         end else if (s_axi_rready) begin
            s_axi_rvalid <= 1'b0;
         end

         weight_valid <= wr_en && (wr_off == REG_WEIGHT);
         bias_valid   <= wr_en && (wr_off == REG_BIAS);
         if (wr_en && wr_off == REG_WEIGHT) weight_data <= s_axi_wdata;
         if (wr_en && wr_off == REG_BIAS)   bias_data   <= s_axi_wdata;
         if (wr_en && wr_off == REG_LAYER)
            layer_number <= merge_strb(layer_number, s_axi_wdata, s_axi_wstrb);
         if (wr_en && wr_off == REG_NEURON)
            neuron_number <= merge_strb(neuron_number, s_axi_wdata, s_axi_wstrb);

         if (result_valid) result_reg <= result_value;
         intr_en <= intr_en_nxt;
         pending <= pending_nxt;
         intr    <= pending_nxt && intr_en_nxt;
      end
   end

   nn_axil_out_fifo #(
      .NUM_OUT (NUM_OUT),
      .OUT_W   (OUT_W)
   ) u_out_fifo (
      .clk         (s_axi_aclk),
      .rst_n       (s_axi_aresetn),
      .capture     (result_valid),
      .neuron_outs (neuron_outs),
      .pop         (pop),
      .clear       (ptr_clear),
      .head        (head)
   );

endmodule
`default_nettype wire
